ex_cond_stage: RTL and testbench

//  Execute-stage consumer of the ID/EX control/data bundle. Evaluates CondE against the NZCV flag register.

---
 rtl/ex_cond_stage.sv | 138 +++++++++++++
 tb/tb_ex_cond_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_cond_stage.sv
// Purpose: execute-stage condition check, NZCV flag update and EX/MEM pipeline register.
// Latency: BranchTakenE is combinational; gated controls and data reach the M outputs 1 cycle later.
// Backpressure: StallE holds the EX/MEM regs, flags, shadow counter and squash counter. Optional COND_STATS_EN adds the squash counter.
module ex_cond_stage #(
    parameter int WIDTH  = 32,
    parameter int SHADOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic             BranchE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlags,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [3:0]       WA3E,
    output logic             BranchTakenE,
    output logic [3:0]       FlagsQ,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [3:0]       WA3M,
    output logic [15:0]      SquashCnt
);

    // Shadow length is limited to 0..3, so two bits of counter suffice.
    localparam logic [1:0] SHADOW_LD = SHADOW[1:0];

    logic       cond_ex;
    logic       live;
    logic       shadow_idle;
    logic [1:0] shadow_q;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign flag_n = FlagsQ[3];
    assign flag_z = FlagsQ[2];
    assign flag_c = FlagsQ[1];
    assign flag_v = FlagsQ[0];

    // ARM condition evaluation against the flags as they stand before this instruction.
    always_comb begin
        cond_ex = 1'b1;
        case (CondE)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = !flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = !flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = !flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = !flag_v;
            4'b1000: cond_ex = flag_c && !flag_z;
            4'b1001: cond_ex = !flag_c || flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ex = flag_z || (flag_n != flag_v);
            default: cond_ex = 1'b1;  // AL and the unused 1111 encoding
        endcase
    end

    assign shadow_idle = (shadow_q == 2'd0);
    assign live        = cond_ex && !FlushE && shadow_idle;

    // Redirect only when the stage actually advances; held low while in reset.
    assign BranchTakenE = BranchE && live && !StallE && reset;

    // NZCV register: the two halves update independently, only for live instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FlagsQ <= 4'b0000;
        end else if (!StallE && live) begin
            if (FlagWriteE[1]) FlagsQ[3:2] <= ALUFlags[3:2];
            if (FlagWriteE[0]) FlagsQ[1:0] <= ALUFlags[1:0];
        end
    end

    // EX/MEM boundary: write-type controls are gated, MemtoReg and data pass through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PCSrcM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WA3M       <= 4'd0;
        end else if (!StallE) begin
            PCSrcM     <= PCSrcE && live;
            RegWriteM  <= RegWriteE && live;
            MemtoRegM  <= MemtoRegE;
            MemWriteM  <= MemWriteE && live;
            ALUOutM    <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
        end
    end

    // Wrong-path shadow: reload on a taken branch, otherwise count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= 2'd0;
        end else if (!StallE) begin
            if (BranchTakenE) begin
                shadow_q <= SHADOW_LD;
            end else if (!shadow_idle) begin
                shadow_q <= shadow_q - 2'd1;
            end
        end
    end

`ifdef COND_STATS_EN
    logic [15:0] squash_q;

    // Count instructions dropped purely by their condition, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            squash_q <= 16'h0000;
        end else if (!StallE && !cond_ex && !FlushE && shadow_idle && (squash_q != 16'hFFFF)) begin
            squash_q <= squash_q + 16'h0001;
        end
    end

    assign SquashCnt = squash_q;
`else
    assign SquashCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ex_cond_stage.sv
module tb_ex_cond_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             StallE, FlushE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE;
    logic [1:0]       FlagWriteE;
    logic [3:0]       CondE, ALUFlags, WA3E;
    logic [WIDTH-1:0] ALUResultE, WriteDataE;
    logic             BranchTakenE, PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [3:0]       FlagsQ, WA3M;
    logic [WIDTH-1:0] ALUOutM, WriteDataM;
    logic [15:0]      SquashCnt;

    int checks   = 0;
    int failures = 0;

    // Flag patterns and the expected condition results, bit index = CondE.
    logic [3:0]  flag_pat [4];
    logic [15:0] cond_exp [4];
    logic [15:0] exp_vec;
    logic [31:0] exp_sq;

    ex_cond_stage #(.WIDTH(WIDTH), .SHADOW(2)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .FlagWriteE(FlagWriteE),
        .CondE(CondE), .ALUFlags(ALUFlags), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .WA3E(WA3E), .BranchTakenE(BranchTakenE),
        .FlagsQ(FlagsQ), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .WA3M(WA3M), .SquashCnt(SquashCnt)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        flag_pat[0] = 4'b0100; cond_exp[0] = 16'b1110_0110_1010_1001;
        flag_pat[1] = 4'b1010; cond_exp[1] = 16'b1110_1001_1001_0110;
        flag_pat[2] = 4'b0011; cond_exp[2] = 16'b1110_1001_0110_0110;
        flag_pat[3] = 4'b1001; cond_exp[3] = 16'b1101_0110_0101_1010;

        reset = 1'b0; StallE = 0; FlushE = 0; PCSrcE = 0; RegWriteE = 0; MemtoRegE = 0;
        MemWriteE = 0; BranchE = 0; FlagWriteE = 2'b00; CondE = 4'hE; ALUFlags = 4'h0;
        ALUResultE = '0; WriteDataE = '0; WA3E = 4'h0;
        #1;
        chk("rst_flags", {28'd0, FlagsQ}, 32'h0);
        chk("rst_ctrl", {28'd0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, 32'h0);
        chk("rst_alu", ALUOutM, 32'h0);
        chk("rst_wd", WriteDataM, 32'h0);
        chk("rst_wa3", {28'd0, WA3M}, 32'h0);
        chk("rst_btk", {31'd0, BranchTakenE}, 32'h0);
        chk("rst_sq", {16'd0, SquashCnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Flag write plus basic register pass-through.
        CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'b0100; RegWriteE = 1;
        ALUResultE = 32'h1234_5678; WriteDataE = 32'hCAFE_0001; WA3E = 4'd5;
        step();
        chk("flags_al", {28'd0, FlagsQ}, 32'h4);
        chk("rw_al", {31'd0, RegWriteM}, 32'h1);
        chk("aluout", ALUOutM, 32'h1234_5678);
        chk("wdata", WriteDataM, 32'hCAFE_0001);
        chk("wa3", {28'd0, WA3M}, 32'h5);
        CondE = 4'h0; FlagWriteE = 2'b00;
        step();
        chk("rw_eq", {31'd0, RegWriteM}, 32'h1);
        CondE = 4'h1; MemtoRegE = 1;
        step();
        chk("rw_ne", {31'd0, RegWriteM}, 32'h0);
        chk("m2r_ungated", {31'd0, MemtoRegM}, 32'h1);
        MemtoRegE = 0; RegWriteE = 0;

        // Independent NZ / CV halves, and no update when the condition fails.
        CondE = 4'hE; FlagWriteE = 2'b10; ALUFlags = 4'b1011;
        step();
        chk("flags_nz", {28'd0, FlagsQ}, 32'h8);
        FlagWriteE = 2'b01; ALUFlags = 4'b0111;
        step();
        chk("flags_cv", {28'd0, FlagsQ}, 32'hB);
        CondE = 4'h0; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
        step();
        chk("flags_condfail", {28'd0, FlagsQ}, 32'hB);

        // Hazard flush kills the write.
        CondE = 4'hE; FlagWriteE = 2'b00; RegWriteE = 1; FlushE = 1;
        step();
        chk("rw_flush", {31'd0, RegWriteM}, 32'h0);
        FlushE = 0; RegWriteE = 0;

        // Full condition table under four flag states, observed on BranchTakenE without a clock edge.
        for (int p = 0; p < 4; p++) begin
            CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = flag_pat[p]; BranchE = 0;
            step();
            chk("flags_set", {28'd0, FlagsQ}, {28'd0, flag_pat[p]});
            FlagWriteE = 2'b00; BranchE = 1;
            exp_vec = cond_exp[p];
            for (int c = 0; c < 16; c++) begin
                CondE = c[3:0];
                #1;
                chk($sformatf("cond_p%0d_c%0d", p, c), {31'd0, BranchTakenE}, {31'd0, exp_vec[c]});
            end
            BranchE = 0; CondE = 4'hE;
        end

        // GE branch with N=V=1, then two wrong-path stores squashed by SHADOW=2.
        CondE = 4'hA; BranchE = 1; PCSrcE = 1;
        #1;
        chk("ge_taken", {31'd0, BranchTakenE}, 32'h1);
        step();
        chk("pcsrc_m", {31'd0, PCSrcM}, 32'h1);
        CondE = 4'hE; MemWriteE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0000;
        #1;
        chk("shadow_nobranch", {31'd0, BranchTakenE}, 32'h0);
        step();
        chk("shadow1_mw", {31'd0, MemWriteM}, 32'h0);
        chk("shadow1_pc", {31'd0, PCSrcM}, 32'h0);
        chk("shadow1_flags", {28'd0, FlagsQ}, 32'h9);
        BranchE = 0; PCSrcE = 0; FlagWriteE = 2'b00;
        step();
        chk("shadow2_mw", {31'd0, MemWriteM}, 32'h0);
        step();
        chk("after_shadow_mw", {31'd0, MemWriteM}, 32'h1);

        // Stall suppresses the branch, then a taken branch followed by a 3-cycle stall+flush.
        MemWriteE = 0; StallE = 1; BranchE = 1;
        #1;
        chk("stall_btk", {31'd0, BranchTakenE}, 32'h0);
        StallE = 0; PCSrcE = 1; ALUResultE = 32'hAAAA_0000;
        step();
        chk("br2_pc", {31'd0, PCSrcM}, 32'h1);
        chk("br2_alu", ALUOutM, 32'hAAAA_0000);
        for (int i = 0; i < 3; i++) begin
            StallE = 1; FlushE = 1; BranchE = 0; PCSrcE = 0; MemWriteE = 1;
            FlagWriteE = 2'b11; ALUFlags = 4'b0110; ALUResultE = 32'hBBBB_0000 + i;
            step();
            chk($sformatf("stall%0d_alu", i), ALUOutM, 32'hAAAA_0000);
            chk($sformatf("stall%0d_flags", i), {28'd0, FlagsQ}, 32'h9);
            chk($sformatf("stall%0d_pc", i), {31'd0, PCSrcM}, 32'h1);
        end
        StallE = 0; FlushE = 0; FlagWriteE = 2'b00; ALUResultE = 32'h0000_00C0;
        step();
        chk("post_stall1_mw", {31'd0, MemWriteM}, 32'h0);
        chk("post_stall1_alu", ALUOutM, 32'h0000_00C0);
        step();
        chk("post_stall2_mw", {31'd0, MemWriteM}, 32'h0);
        step();
        chk("post_stall3_mw", {31'd0, MemWriteM}, 32'h1);

        // Reset in the middle of a shadow window.
        MemWriteE = 0; BranchE = 1; PCSrcE = 1; RegWriteE = 1; CondE = 4'hE;
        step();
        chk("pre_rst_rw", {31'd0, RegWriteM}, 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_ctrl", {28'd0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM}, 32'h0);
        chk("midrst_flags", {28'd0, FlagsQ}, 32'h0);
        chk("midrst_alu", ALUOutM, 32'h0);
        chk("midrst_wa3", {28'd0, WA3M}, 32'h0);
        chk("midrst_btk", {31'd0, BranchTakenE}, 32'h0);
        #1;
        reset = 1'b1; BranchE = 0; PCSrcE = 0; ALUResultE = 32'h0000_00D0;
        step();
        chk("postrst_rw", {31'd0, RegWriteM}, 32'h1);
        chk("postrst_alu", ALUOutM, 32'h0000_00D0);

        // Condition-fail statistics: five NE with Z=1, then a flushed and a stalled one.
        RegWriteE = 0; CondE = 4'hE; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
        step();
        FlagWriteE = 2'b00; CondE = 4'h1;
        for (int i = 0; i < 5; i++) step();
`ifdef COND_STATS_EN
        exp_sq = 32'd5;
`else
        exp_sq = 32'd0;
`endif
        chk("squash5", {16'd0, SquashCnt}, exp_sq);
        FlushE = 1;
        step();
        FlushE = 0; StallE = 1;
        step();
        StallE = 0;
        chk("squash_hold", {16'd0, SquashCnt}, exp_sq);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
